framebuffer_clear: RTL

- Upstream stage of framebuffer_read: fills the selected back buffer in HPS SDRAM with a solid background colour before each frame is rasterised.
- Masters a 64-bit Avalon-MM burst write port (f2h SDRAM write side). Each 32-bit 0x00RRGGBB pixel is packed two per word.
- Started by the register file or the frame sequencer. Reports busy/done so the rasteriser waits until the clear has finished.

---
 rtl/fb_pkg.sv | 15 +
 rtl/framebuffer_clear.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer constants shared with framebuffer_read, clear FSM states and a burst-length helper.
package fb_pkg;
  localparam int AV_ADDR_W = 29;
  localparam int AV_DATA_W = 64;
  localparam int AV_BURST_W = 8;
  localparam int PIXEL_W = 32;
  localparam int FB_WIDTH_PX = 640;
  localparam int FB_HEIGHT_PX = 480;
  localparam logic [AV_ADDR_W-1:0] FB_BASE_ADDR0 = 29'h0000000;
  localparam logic [AV_ADDR_W-1:0] FB_BASE_ADDR1 = 29'h0025800;
  typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;
  function automatic logic [AV_BURST_W-1:0] burst_of(input logic [AV_ADDR_W-1:0] rem, input logic [AV_BURST_W-1:0] len);
    return (rem < AV_ADDR_W'(len)) ? rem[AV_BURST_W-1:0] : len;
  endfunction
endpackage

// File: rtl/framebuffer_clear.sv
// framebuffer_clear: fills a back buffer with one colour using 64-bit Avalon-MM burst writes.
// Define FBCLEAR_ABORT_EN to add an abort input that ends the clear after the current burst.
module framebuffer_clear
  import fb_pkg::*;
#(
  parameter int WIDTH_PX = FB_WIDTH_PX,
  parameter int HEIGHT_PX = FB_HEIGHT_PX,
  parameter int BURST_LEN = 8,
  parameter logic [AV_ADDR_W-1:0] BASE_ADDR0 = FB_BASE_ADDR0,
  parameter logic [AV_ADDR_W-1:0] BASE_ADDR1 = FB_BASE_ADDR1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  buffer,
  input  logic [PIXEL_W-1:0]    colour,
`ifdef FBCLEAR_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [AV_ADDR_W-1:0]  address,
  output logic [AV_BURST_W-1:0] burstcount,
  output logic [AV_DATA_W-1:0]  writedata,
  output logic [7:0]            byteenable,
  output logic                  write,
  input  logic                  waitrequest
);
  localparam logic [AV_ADDR_W-1:0] TOTAL_WORDS = AV_ADDR_W'(WIDTH_PX * HEIGHT_PX / 2);
  localparam logic [AV_BURST_W-1:0] BLEN = AV_BURST_W'(BURST_LEN);
  if ((WIDTH_PX * HEIGHT_PX) % 2 != 0) begin : g_odd_pixels
    $error("framebuffer_clear: WIDTH_PX*HEIGHT_PX must be even");
  end
  if (BURST_LEN < 1 || BURST_LEN > 128) begin : g_bad_burst
    $error("framebuffer_clear: BURST_LEN must be 1..128");
  end
  state_t                 state_q, state_d;
  logic [PIXEL_W-1:0]     colour_q, colour_d;
  logic [AV_ADDR_W-1:0]   address_q, address_d;
  logic [AV_ADDR_W-1:0]   rem_q, rem_d;
  logic [AV_BURST_W-1:0]  burstcount_q, burstcount_d;
  logic [AV_BURST_W-1:0]  beat_q, beat_d;
  logic                   write_q, write_d;
  logic                   abort_hit;
`ifdef FBCLEAR_ABORT_EN
  logic abort_q;
  assign abort_hit = abort_q | abort;
  always_ff @(posedge clock) begin
    if (reset) abort_q <= 1'b0;
    else abort_q <= (state_q == BURST) & abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif
  // The first BURST cycle loads the registered Avalon outputs from remaining; write rises after it.
  always_comb begin
    state_d = state_q;
    colour_d = colour_q;
    address_d = address_q;
    rem_d = rem_q;
    burstcount_d = burstcount_q;
    beat_d = beat_q;
    write_d = write_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = BURST;
        colour_d = colour;
        address_d = buffer ? BASE_ADDR1 : BASE_ADDR0;
        rem_d = TOTAL_WORDS;
      end
      BURST: if (!write_q) begin
        state_d = abort_hit ? FINISH : BURST;
        write_d = !abort_hit;
        burstcount_d = burst_of(rem_q, BLEN);
        beat_d = '0;
      end else if (!waitrequest) begin
        rem_d = rem_q - 29'd1;
        beat_d = beat_q + 8'd1;
        if (beat_q == burstcount_q - 8'd1) begin
          beat_d = '0;
          if (rem_q == 29'd1 || abort_hit) begin
            state_d = FINISH;
            write_d = 1'b0;
          end else begin
            address_d = address_q + AV_ADDR_W'(burstcount_q);
            burstcount_d = burst_of(rem_q - 29'd1, BLEN);
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      colour_q <= '0;
      address_q <= '0;
      rem_q <= '0;
      burstcount_q <= '0;
      beat_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      colour_q <= colour_d;
      address_q <= address_d;
      rem_q <= rem_d;
      burstcount_q <= burstcount_d;
      beat_q <= beat_d;
      write_q <= write_d;
    end
  end
  assign busy = state_q == BURST;
  assign done = state_q == FINISH;
  assign write = write_q;
  assign address = address_q;
  assign burstcount = burstcount_q;
  assign writedata = {colour_q, colour_q};
  assign byteenable = {8{write_q}};
endmodule
